// File: rtl/pipelined_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Holds the operation encoding and a width-generic bit reversal.
package cpu_shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_ROR = 2'b10,
    SHIFT_SRA = 2'b11
  } shift_op_e;

  // Widest operand the reversal helper supports; callers cast to their width.
  localparam int unsigned MaxDataW = 256;
  localparam int unsigned MaxIdxW  = $clog2(MaxDataW);

  // Reverses the low `width` bits of `data`; bits above `width` come back as zero.
  function automatic logic [MaxDataW-1:0] bit_reverse(input logic [MaxDataW-1:0] data,
                                                      input int unsigned       width);
    logic [MaxDataW-1:0] rev;
    rev = '0;
    for (int unsigned i = 0; i < MaxDataW; i++) begin
      if (i < width) begin
        rev[MaxIdxW'(i)] = data[MaxIdxW'(width - 1 - i)];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Request/response handshake bundle between issue logic and the shifter.
// master = issue side, slave = shifter.
interface pipelined_shifter_if
  import cpu_shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) ();

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  shift_op_e         in_op_i;
  logic [DATA_W-1:0] in_data_i;
  logic [DATA_W-1:0] in_shamt_i;
  logic [TAG_W-1:0]  in_tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [TAG_W-1:0]  out_tag_o;

  modport master (
    output flush_i, in_valid_i, in_op_i, in_data_i, in_shamt_i, in_tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_tag_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_op_i, in_data_i, in_shamt_i, in_tag_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_tag_o
  );

endinterface

// File: rtl/pipelined_shifter_stage.sv
// One conditional right-shift-by-AMT step of the barrel shifter.
// Purely combinational; the enclosing pipeline owns the registers.
module shift_stage
  import cpu_shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT    = 1
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic              shift_en,
  input  shift_op_e         op,
  input  logic              sign,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (shift_en) begin
      case (op)
        SHIFT_ROR: data_out = {data_in[AMT-1:0], data_in[DATA_W-1:AMT]};
        SHIFT_SRA: data_out = {{AMT{sign}}, data_in[DATA_W-1:AMT]};
        // SLL arrives bit-reversed, so it shares the zero-fill right shift with SRL.
        default:   data_out = {{AMT{1'b0}}, data_in[DATA_W-1:AMT]};
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(DATA_W) power-of-two stages, one register each,
// with valid/ready on both sides, bubble collapsing, flush and a sideband tag.
module pipelined_shifter
  import cpu_shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input logic                clk_i,
  input logic                rst_i,
  pipelined_shifter_if.slave sh
);

  localparam int unsigned SHAMT_W = $clog2(DATA_W);
  localparam int unsigned Last    = SHAMT_W - 1;

  logic [SHAMT_W-1:0]              valid_q;
  logic [SHAMT_W-1:0]              valid_src;
  logic [SHAMT_W-1:0]              adv;
  logic [DATA_W-1:0]               data_q  [SHAMT_W];
  logic [DATA_W-1:0]               stg_in  [SHAMT_W];
  logic [DATA_W-1:0]               stg_out [SHAMT_W];
  shift_op_e                       op_q    [SHAMT_W];
  shift_op_e                       op_src  [SHAMT_W];
  logic [TAG_W-1:0]                tag_q   [SHAMT_W];
  logic [TAG_W-1:0]                tag_src [SHAMT_W];
  logic [SHAMT_W-1:0][SHAMT_W-1:0] shamt_q;
  logic [SHAMT_W-1:0][SHAMT_W-1:0] shamt_src;
  logic [SHAMT_W-1:0]              sign_q;
  logic [SHAMT_W-1:0]              sign_src;
  logic [DATA_W-1:0]               entry_data;

  // SLL is computed as a right shift on the mirrored operand.
  assign entry_data = (sh.in_op_i == SHIFT_SLL) ?
                      DATA_W'(bit_reverse(MaxDataW'(sh.in_data_i), DATA_W)) : sh.in_data_i;

  assign valid_src = {valid_q[SHAMT_W-2:0], sh.in_valid_i};

  always_comb begin
    stg_in[0]    = entry_data;
    op_src[0]    = sh.in_op_i;
    tag_src[0]   = sh.in_tag_i;
    shamt_src[0] = sh.in_shamt_i[SHAMT_W-1:0];
    sign_src[0]  = (sh.in_op_i == SHIFT_SRA) & sh.in_data_i[DATA_W-1];
    for (int k = 1; k < SHAMT_W; k++) begin
      stg_in[k]    = data_q[k-1];
      op_src[k]    = op_q[k-1];
      tag_src[k]   = tag_q[k-1];
      shamt_src[k] = shamt_q[k-1];
      sign_src[k]  = sign_q[k-1];
    end
  end

  // A stage may load when it is empty or its occupant moves on downstream.
  always_comb begin
    adv       = '0;
    adv[Last] = !valid_q[Last] | sh.out_ready_i;
    for (int k = int'(SHAMT_W) - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k] | adv[k+1];
    end
  end

  assign sh.in_ready_o = adv[0];

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .DATA_W (DATA_W),
      .AMT    (2 ** k)
    ) u_stage (
      .data_in  (stg_in[k]),
      .shift_en (shamt_src[k][k]),
      .op       (op_src[k]),
      .sign     (sign_src[k]),
      .data_out (stg_out[k])
    );
  end

  // Flush and reset both empty the pipe; an input offered alongside a flush is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i || sh.flush_i) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_src[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < SHAMT_W; k++) begin
      if (adv[k] && valid_src[k]) begin
        data_q[k]  <= stg_out[k];
        op_q[k]    <= op_src[k];
        tag_q[k]   <= tag_src[k];
        shamt_q[k] <= shamt_src[k];
        sign_q[k]  <= sign_src[k];
      end
    end
  end

  assign sh.out_valid_o = valid_q[Last];

  always_comb begin
    sh.out_data_o = '0;
    sh.out_tag_o  = '0;
    if (valid_q[Last]) begin
      sh.out_tag_o  = tag_q[Last];
      sh.out_data_o = (op_q[Last] == SHIFT_SLL) ?
                      DATA_W'(bit_reverse(MaxDataW'(data_q[Last]), DATA_W)) : data_q[Last];
    end
  end

  // Stages consume only their own shamt bit; the sign of the last stage has no reader.
  logic unused_bits;
  assign unused_bits = ^{sh.in_shamt_i[DATA_W-1:SHAMT_W], shamt_q, sign_q};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (DATA_W=32) against an arithmetic shift model.
module tb_pipelined_shifter;
  import cpu_shift_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.DATA_W(DW), .TAG_W(TW)) sh ();

  pipelined_shifter #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sh    (sh)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          last_acc;
  bit          toggle_rdy = 1'b0;
  logic [31:0] exp_d[$];
  logic [31:0] got_d[$];
  logic [4:0]  exp_t[$];
  logic [4:0]  got_t[$];
  int          acc_cyc[$];
  int          got_cyc[$];

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [31:0] s);
    int unsigned amt;
    amt = s % 32;
    case (op)
      2'd0:    return d << amt;
      2'd1:    return d >> amt;
      2'd2:    return (d >> amt) | (d << (32 - amt));
      default: return 32'($signed(d) >>> amt);
    endcase
  endfunction

  // One clock: sample handshakes at the falling edge, update the model, return after the edge.
  task automatic tick();
    bit acc, pop;
    @(negedge clk);
    acc = sh.in_valid_i && sh.in_ready_o && !sh.flush_i && !rst;
    pop = sh.out_valid_o && sh.out_ready_i && !rst;
    if (pop) begin
      got_d.push_back(sh.out_data_o);
      got_t.push_back(sh.out_tag_o);
      got_cyc.push_back(cyc);
    end
    if (sh.flush_i || rst) begin
      while (exp_d.size() > got_d.size()) begin
        void'(exp_d.pop_back());
        void'(exp_t.pop_back());
        void'(acc_cyc.pop_back());
      end
    end else if (acc) begin
      exp_d.push_back(ref_shift(sh.in_op_i, sh.in_data_i, sh.in_shamt_i));
      exp_t.push_back(sh.in_tag_i);
      acc_cyc.push_back(cyc);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    if (toggle_rdy) sh.out_ready_i = !sh.out_ready_i;
  endtask

  task automatic clear_q();
    exp_d.delete(); got_d.delete(); exp_t.delete(); got_t.delete();
    acc_cyc.delete(); got_cyc.delete();
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s,
                      input logic [4:0] t, output bit ok);
    sh.in_valid_i = 1'b1;
    sh.in_op_i    = shift_op_e'(op);
    sh.in_data_i  = d;
    sh.in_shamt_i = s;
    sh.in_tag_i   = t;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = last_acc;
    end
    sh.in_valid_i = 1'b0;
  endtask

  task automatic drain(output bit ok);
    sh.in_valid_i = 1'b0;
    sh.flush_i    = 1'b0;
    toggle_rdy    = 1'b0;
    sh.out_ready_i = 1'b1;
    for (int i = 0; i < 40 && got_d.size() < exp_d.size(); i++) tick();
    repeat (6) tick();
    ok = (got_d.size() == exp_d.size());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (sh.out_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", sh.out_valid_o);
    end
    checks++;
    if (sh.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", sh.in_ready_o);
    end
    checks++;
    if (sh.out_data_o !== 32'h0 || sh.out_tag_o !== 5'h0) begin
      errors++;
      $display("FAIL reset_out_zero: got %h/%h expected 0/0", sh.out_data_o, sh.out_tag_o);
    end
    clear_q();
  endtask

  task automatic test_basic_ops();
    logic [31:0] expv[4];
    logic [1:0]  ops[4];
    bit ok, all_ok;
    expv = '{32'h0800_000F, 32'hF800_000F, 32'h0000_0F00, 32'h0800_000F};
    ops  = '{2'd1, 2'd3, 2'd0, 2'd2};
    clear_q();
    sh.out_ready_i = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], 32'h8000_00F0, 32'd4, 5'(i + 1), ok);
      all_ok &= ok;
    end
    drain(ok);
    checks++;
    if (!ok || !all_ok) begin
      errors++; $display("FAIL basic_count: got %0d results expected 4", got_d.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_d[i] !== expv[i] || got_t[i] !== 5'(i + 1)) begin
        errors++;
        $display("FAIL basic_op[%0d]: got %h tag %0d expected %h tag %0d",
                 i, got_d[i], got_t[i], expv[i], i + 1);
      end
      checks++;
      if (got_cyc[i] - acc_cyc[i] != 5) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got %0d expected 5", i, got_cyc[i] - acc_cyc[i]);
      end
    end
    checks++;
    if (acc_cyc[3] - acc_cyc[0] != 3) begin
      errors++;
      $display("FAIL basic_throughput: got %0d cycles expected 3", acc_cyc[3] - acc_cyc[0]);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] expb[6];
    logic [31:0] d;
    bit ok;
    clear_q();
    sh.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      expb[i] = d;
      send(2'(i), d, 32'd0, 5'(10 + i), ok);
    end
    expb[4] = 32'hFFFF_FFFF;
    send(2'd3, 32'h8000_0000, 32'd31, 5'd14, ok);
    expb[5] = 32'h1;
    send(2'd1, 32'h2, 32'h0000_0021, 5'd15, ok);
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bound_count: got %0d results expected 6", got_d.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_d[i] !== expb[i] || got_t[i] !== 5'(10 + i)) begin
        errors++;
        $display("FAIL boundary[%0d]: got %h tag %0d expected %h tag %0d",
                 i, got_d[i], got_t[i], expb[i], 10 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  bo[8];
    logic [31:0] bd[8];
    logic [31:0] bs[8];
    bit ok;
    for (int i = 0; i < 8; i++) begin
      bo[i] = 2'($urandom_range(0, 3)); bd[i] = $urandom; bs[i] = $urandom;
    end
    clear_q();
    sh.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send(bo[i], bd[i], bs[i], 5'(i), ok);
    checks++;
    if (sh.in_ready_o !== 1'b0 || sh.out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: got in_ready %b out_valid %b expected 0 1",
               sh.in_ready_o, sh.out_valid_o);
    end
    sh.in_valid_i = 1'b1;
    sh.in_op_i    = shift_op_e'(bo[5]);
    sh.in_data_i  = bd[5];
    sh.in_shamt_i = bs[5];
    sh.in_tag_i   = 5'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (last_acc || sh.out_data_o !== exp_d[0] || sh.out_tag_o !== 5'd0) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got acc %b data %h tag %0d expected 0 %h 0",
                 i, last_acc, sh.out_data_o, sh.out_tag_o, exp_d[0]);
      end
    end
    sh.out_ready_i = 1'b1;
    for (int i = 5; i < 8; i++) send(bo[i], bd[i], bs[i], 5'(i), ok);
    drain(ok);
    checks++;
    if (!ok || got_d.size() != 8) begin
      errors++; $display("FAIL bp_count: got %0d results expected 8", got_d.size());
    end
    checks++;
    if (acc_cyc[5] != got_cyc[0]) begin
      errors++;
      $display("FAIL bp_push_pop: got accept cycle %0d expected %0d", acc_cyc[5], got_cyc[0]);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_t[i] !== 5'(i)) begin
        errors++;
        $display("FAIL bp_result[%0d]: got %h tag %0d expected %h tag %0d",
                 i, got_d[i], got_t[i], exp_d[i], i);
      end
    end
  endtask

  task automatic test_bubbles();
    bit ok;
    clear_q();
    sh.out_ready_i = 1'b1;
    toggle_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(i), ok);
      tick();
    end
    drain(ok);
    checks++;
    if (!ok || got_d.size() != 12) begin
      errors++; $display("FAIL bubble_count: got %0d results expected 12", got_d.size());
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_t[i] !== 5'(i)) begin
        errors++;
        $display("FAIL bubble_result[%0d]: got %h tag %0d expected %h tag %0d",
                 i, got_d[i], got_t[i], exp_d[i], i);
      end
    end
  endtask

  task automatic test_flush();
    bit ok;
    clear_q();
    sh.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) send(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(i), ok);
    sh.in_valid_i = 1'b1;
    sh.in_data_i  = $urandom;
    sh.in_tag_i   = 5'd3;
    sh.flush_i    = 1'b1;
    tick();
    sh.flush_i    = 1'b0;
    sh.in_valid_i = 1'b0;
    checks++;
    if (sh.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_in_ready: got %b expected 1", sh.in_ready_o);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (sh.out_valid_o !== 1'b0) begin
        errors++; $display("FAIL flush_out_valid[%0d]: got %b expected 0", i, sh.out_valid_o);
      end
      tick();
    end
    send(2'd1, 32'h0000_00F0, 32'd4, 5'd7, ok);
    drain(ok);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 32'h0000_000F || got_t[0] !== 5'd7) begin
      errors++;
      $display("FAIL flush_after: got %0d results first %h tag %0d expected 1 0000000f tag 7",
               got_d.size(), got_d[0], got_t[0]);
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    clear_q();
    sh.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(i), ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (sh.out_valid_o !== 1'b0 || sh.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got out_valid %b in_ready %b expected 0 1",
               sh.out_valid_o, sh.in_ready_o);
    end
    sh.out_ready_i = 1'b1;
    repeat (8) tick();
    checks++;
    if (got_d.size() != 0) begin
      errors++; $display("FAIL rst_stale: got %0d results expected 0", got_d.size());
    end
    send(2'd2, 32'h0000_0001, 32'd1, 5'd9, ok);
    drain(ok);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 32'h8000_0000 || got_t[0] !== 5'd9) begin
      errors++;
      $display("FAIL rst_after: got %0d results first %h tag %0d expected 1 80000000 tag 9",
               got_d.size(), got_d[0], got_t[0]);
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_q();
    for (int n = 0; n < 80; n++) begin
      sh.in_valid_i  = ($urandom_range(0, 3) != 0);
      sh.in_op_i     = shift_op_e'($urandom_range(0, 3));
      sh.in_data_i   = $urandom;
      sh.in_shamt_i  = $urandom;
      sh.in_tag_i    = 5'(n);
      sh.out_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rand_count: got %0d results expected %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
        errors++;
        $display("FAIL rand_result[%0d]: got %h tag %0d expected %h tag %0d",
                 i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
      end
    end
  endtask

  initial begin
    sh.flush_i     = 1'b0;
    sh.in_valid_i  = 1'b0;
    sh.in_op_i     = SHIFT_SLL;
    sh.in_data_i   = '0;
    sh.in_shamt_i  = '0;
    sh.in_tag_i    = '0;
    sh.out_ready_i = 1'b1;
    test_reset();
    test_basic_ops();
    test_boundaries();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined barrel shifter for the CPU execute path. Supports logical left, logical right, arithmetic right and rotate right on a DATA_W-bit operand. The operand passes through log2(DATA_W) conditional power-of-two shift stages, each followed by a pipeline register. Valid/ready handshakes on both sides allow back-pressure and bubble collapsing, and a sideband tag travels with each operation so the issue logic can match results to destinations.

## Interface
- DATA_W, 32: operand width; power of two, ≥ 8.
- TAG_W, 5: width of the opaque tag carried with each operation (e.g. rd index).
- SHAMT_W (localparam) = $clog2(DATA_W); number of stages = SHAMT_W.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  drop all in-flight operations.
- in_valid_i  in  1  request present.
- in_ready_o  out  1  block accepts request this cycle.
- in_op_i  in  2  shift_op_e: SLL=00, SRL=01, ROR=10, SRA=11.
- in_data_i  in  DATA_W  operand (rs1).
- in_shamt_i  in  DATA_W  shift amount; only bits [SHAMT_W-1:0] used, upper bits ignored.
- in_tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  result present.
- out_ready_i  in  1  consumer accepts result.
- out_data_o  out  DATA_W  result (rd).
- out_tag_o  out  TAG_W  tag of the result.

## Operation
- Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i.
- Entry: SLL is mapped onto right shift by bit-reversing the operand. A per-op flag records whether the output must be reversed back. The fill bit is latched: 0 for SLL/SRL, in_data_i[DATA_W-1] for SRA, and wrap-around for ROR.
- Stage k (k = 0..SHAMT_W-1): if shamt[k], shift right by 2^k.
  - SRL/SLL: fill the vacated MSBs with 0.
  - SRA: fill the vacated MSBs with the latched sign.
  - ROR: fill the vacated MSBs with the bits shifted out.
- Each stage register holds: valid, data, remaining shamt bits, op, sign, tag.
- Exit: the last stage output is bit-reversed if op == SLL, then driven on out_data_o.
- Shamt 0 returns the operand unchanged for every op.
- Bubble collapsing:
  - Stage k advances when its register is empty, or stage k+1 advances.
  - The last stage advances when it is empty, or out_ready_i is high.
  - in_ready_o = !valid[0] | advance[0]. This is combinational from out_ready_i through the valid chain.
- Stalled stage: holds data, op and tag stable. out_data_o and out_tag_o stay stable while out_valid_o & !out_ready_i.
- flush_i:
  - Clears every valid bit on the next edge.
  - A request presented in the same cycle as flush_i is dropped, even if in_ready_o is high.
  - Flush has priority over advance.
- Reset clears all valid bits. out_valid_o = 0 and in_ready_o = 1 in the first cycle after reset. The datapath registers need no reset; out_data_o and out_tag_o are 0 after reset only because the output is gated by valid.
- Reset mid-operation discards all in-flight results with no partial output.

## Timing
- Latency: SHAMT_W cycles from input transfer to out_valid_o (5 for DATA_W=32), with out_ready_i held high.
- Throughput: one operation per cycle with no back-pressure.
- Capacity: SHAMT_W operations in flight.
- Full pipeline with out_ready_i low: in_ready_o = 0 in the same cycle.
- Simultaneous output pop and input push when full: both accepted, pipeline shifts by one.
- out_valid_o, out_data_o and out_tag_o come directly from registers, except the combinational SLL reversal; no path from in_* to out_*.

## Structure
- Package cpu_shift_pkg:
  - typedef enum logic [1:0] shift_op_e {SHIFT_SLL, SHIFT_SRL, SHIFT_ROR, SHIFT_SRA}.
  - function bit_reverse(DATA_W).
- Sub-module shift_stage:
  - Parameters DATA_W, AMT (= 2^k).
  - Combinational conditional shift with fill mode.
  - Instantiated SHAMT_W times via generate.
  - Registers and handshake live in pipelined_shifter.

## Test plan
- Basic ops, DATA_W=32, out_ready_i=1, operand 0x8000_00F0, shamt 4:
  - SRL → 0x0800_000F.
  - SRA → 0xF800_000F.
  - SLL → 0x0000_0F00.
  - ROR → 0x0800_000F.
  - Each with out_valid_o exactly 5 cycles after accept and tags 1–4 returned in order.
- Boundaries:
  - Shamt 0 → operand unchanged.
  - Shamt 31, SRA on 0x8000_0000 → 0xFFFF_FFFF.
  - in_shamt_i = 0x0000_0021 treated as 1; SRL of 0x2 → 0x1.
- Back-pressure:
  - Stream 8 ops with out_ready_i low: in_ready_o drops after the 5th accept.
  - out_data_o stays stable while stalled.
  - Raise out_ready_i: all 8 results are delivered in order with no loss or duplication.
- Bubbles: insert a 1-cycle gap between ops while out_ready_i toggles 1010…; outputs match a golden model in order.
- Flush with 3 ops in flight plus a request the same cycle:
  - No out_valid_o afterwards.
  - in_ready_o = 1 the next cycle.
  - A new op issued after the flush is returned correctly.
- Reset mid-stream: assert rst_i for 1 cycle with the pipe full → out_valid_o = 0 the next cycle, and no stale results appear.
